// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   state_e        : arbiter FSM state encoding
//   BYTE_W         : width of one UART data byte
//   DEF_STROBE_LEN : default start-strobe length in cycles
//   DEF_GAP_CYCLES : default idle gap between frames in cycles
//   max3()         : helper used to size the shared cycle counter
package uart_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_STROBE_LEN = 4;
    localparam int DEF_GAP_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req     : request vector
//   ptr     : index with highest priority this round
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of the granted bit
//   gnt_vld : any request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    // Walk the offsets from farthest to nearest so the nearest set bit
    // (searching upward from ptr with wrap) is the last one written.
    always_comb begin
        int j;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                gnt     = '0;
                gnt[j]  = 1'b1;
                gnt_idx = IDX_W'(j);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ
// requesters. Sequences one frame at a time: grant + strobe, wait for the
// transmitter to go busy (with timeout), wait for it to finish, idle gap.
//   clk, rst     : clock, asynchronous active-high reset
//   req          : per-requester level request, held until ack
//   req_data     : requester i byte on [8i+7:8i]
//   ack          : one-cycle pulse, byte of requester i latched
//   tx_data      : byte to the transmitter, held until the next grant
//   tx_int       : start strobe, its falling edge starts the frame
//   tx_busy      : transmitter frame-in-progress flag
//   grant_id     : current or last granted requester
//   busy         : high whenever the FSM is not IDLE
//   err_timeout  : one-cycle pulse when the transmitter never went busy
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int STROBE_LEN   = DEF_STROBE_LEN,
    parameter int BUSY_TIMEOUT = 64,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [BYTE_W-1:0]          tx_data,
    output logic                       tx_int,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(max3(STROBE_LEN, BUSY_TIMEOUT, GAP_CYCLES) + 1);

    // With a zero gap the frame end goes straight back to IDLE.
    localparam state_e POST_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_e                          state;
    logic [IDX_W-1:0]                ptr;
    logic [CNT_W-1:0]                cnt;
    logic [NUM_REQ-1:0]              gnt;
    logic [IDX_W-1:0]                gnt_idx;
    logic                            gnt_vld;
    logic [NUM_REQ-1:0][BYTE_W-1:0]  data_arr;

    assign data_arr = req_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            ack         <= '0;
            tx_data     <= '0;
            tx_int      <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ack         <= '0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        ack      <= gnt;
                        tx_data  <= data_arr[gnt_idx];
                        grant_id <= gnt_idx;
                        tx_int   <= 1'b1;
                        ptr      <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        // The grant cycle is the first strobe cycle.
                        cnt      <= CNT_W'(1);
                        busy     <= 1'b1;
                        state    <= STROBE;
                    end
                end
                STROBE: begin
                    if (cnt == CNT_W'(STROBE_LEN)) begin
                        tx_int <= 1'b0;
                        cnt    <= '0;
                        state  <= WAIT_BUSY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    // An X/Z busy flag falls to the else branch, i.e. reads as 0.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                        busy        <= (POST_FRAME != IDLE);
                        state       <= POST_FRAME;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        cnt   <= '0;
                        busy  <= (POST_FRAME != IDLE);
                        state <= POST_FRAME;
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
